// File: rtl/csa_pkg.sv
// Shared constants for the carry-select adder (csa) and its nibble adder.
// CSA_WIDTH is the operand width; CSA_BLOCK is the ripple block size that
// the carry-select structure is built from.
package csa_pkg;

    localparam int CSA_WIDTH = 8;
    localparam int CSA_BLOCK = 4;

endpackage : csa_pkg

// File: rtl/csa_rca4.sv
// Four-bit ripple-carry adder used as the building block of csa.
// Besides the sum and carry-out it exposes the carry into its top bit (c3),
// which the parent uses to derive signed overflow of the full word.
module csa_rca4
    import csa_pkg::*;
(
    input  logic [CSA_BLOCK-1:0] a,
    input  logic [CSA_BLOCK-1:0] b,
    input  logic                 ci,
    output logic [CSA_BLOCK-1:0] s,
    output logic                 co,
    output logic                 c3
);

    logic [CSA_BLOCK:0] carry;

    // Ripple the carry bit by bit through the block.
    always_comb begin
        carry    = '0;
        s        = '0;
        carry[0] = ci;
        for (int i = 0; i < CSA_BLOCK; i++) begin
            s[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

    assign co = carry[CSA_BLOCK];
    assign c3 = carry[CSA_BLOCK-1];

endmodule : csa_rca4

// File: rtl/csa.sv
// Registered 8-bit add/subtract unit built as a carry-select adder.
// cin = 0 adds (A+B); cin = 1 subtracts (A-B) by inverting B and feeding
// cin as carry-in. Low nibble ripples, the high nibble is precomputed for
// both carry values and the low carry-out picks one.
// Optional feature: define CSA_OVERFLOW_EN to build the signed-overflow flag;
// without it the overflow port is tied to 0 and its logic is absent.
module csa
    import csa_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CSA_WIDTH-1:0] A,
    input  logic [CSA_WIDTH-1:0] B,
    input  logic                 cin,
    output logic [CSA_WIDTH-1:0] S,
    output logic                 cout,
    output logic                 overflow
);

    logic [CSA_WIDTH-1:0] b_eff;
    logic [CSA_BLOCK-1:0] lo_sum;
    logic                 lo_co;
    logic                 lo_c3;
    logic [CSA_BLOCK-1:0] hi0_sum;
    logic                 hi0_co;
    logic                 hi0_c3;
    logic [CSA_BLOCK-1:0] hi1_sum;
    logic                 hi1_co;
    logic                 hi1_c3;
    logic [CSA_WIDTH-1:0] sum_next;
    logic                 cout_next;

    assign b_eff = B ^ {CSA_WIDTH{cin}};

    csa_rca4 u_lo (
        .a  (A[CSA_BLOCK-1:0]),
        .b  (b_eff[CSA_BLOCK-1:0]),
        .ci (cin),
        .s  (lo_sum),
        .co (lo_co),
        .c3 (lo_c3)
    );

    csa_rca4 u_hi0 (
        .a  (A[CSA_WIDTH-1:CSA_BLOCK]),
        .b  (b_eff[CSA_WIDTH-1:CSA_BLOCK]),
        .ci (1'b0),
        .s  (hi0_sum),
        .co (hi0_co),
        .c3 (hi0_c3)
    );

    csa_rca4 u_hi1 (
        .a  (A[CSA_WIDTH-1:CSA_BLOCK]),
        .b  (b_eff[CSA_WIDTH-1:CSA_BLOCK]),
        .ci (1'b1),
        .s  (hi1_sum),
        .co (hi1_co),
        .c3 (hi1_c3)
    );

    assign sum_next  = {(lo_co ? hi1_sum : hi0_sum), lo_sum};
    assign cout_next = lo_co ? hi1_co : hi0_co;

    // Capture the selected sum and carry; reset clears them at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= '0;
            cout <= 1'b0;
        end else begin
            S    <= sum_next;
            cout <= cout_next;
        end
    end

`ifdef CSA_OVERFLOW_EN
    logic c7;
    logic ovf_next;
    logic unused_carry;

    assign c7           = lo_co ? hi1_c3 : hi0_c3;
    assign ovf_next     = c7 ^ cout_next;
    assign unused_carry = lo_c3;

    // Signed overflow: carry into bit 7 disagrees with carry out of bit 7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else begin
            overflow <= ovf_next;
        end
    end
`else
    logic unused_carry;

    assign unused_carry = ^{lo_c3, hi0_c3, hi1_c3};
    assign overflow     = 1'b0;
`endif

endmodule : csa

// File: tb/tb_csa.sv
// Self-checking bench for csa: directed corner vectors, asynchronous reset
// behaviour and a 1000-vector random back-to-back stream, all compared with
// an arithmetic reference model. Outputs are sampled on the falling edge.
module tb_csa;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
    logic       overflow;

    int assertCount;
    int failCount;

    logic       pendValid;
    logic [9:0] pendExpected;
    string      pendTag;

    csa dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .cin      (cin),
        .S        (s),
        .cout     (cout),
        .overflow (overflow)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result packed as {S, cout, overflow}, from integer arithmetic.
    function automatic logic [9:0] refModel(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic rc);
        int unsignedSum;
        int signedRes;
        logic [7:0] sumByte;
        logic carry;
        logic ovf;
        if (rc == 1'b0) begin
            unsignedSum = int'(ra) + int'(rb);
            signedRes   = int'($signed(ra)) + int'($signed(rb));
        end else begin
            unsignedSum = int'(ra) - int'(rb) + 256;
            signedRes   = int'($signed(ra)) - int'($signed(rb));
        end
        sumByte = unsignedSum[7:0];
        carry   = (unsignedSum >= 256);
`ifdef CSA_OVERFLOW_EN
        ovf = (signedRes > 127) || (signedRes < -128);
`else
        ovf = 1'b0;
`endif
        return {sumByte, carry, ovf};
    endfunction

    // Single comparison point: counts and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got S=%h cout=%b ovf=%b, want S=%h cout=%b ovf=%b",
                     tag, observed[9:2], observed[1], observed[0],
                     expected[9:2], expected[1], expected[0]);
        end
    endtask

    // On each falling edge: check the previous vector's result, then drive a new one.
    task automatic applyStimulus(input string tag, input logic [7:0] va,
                                 input logic [7:0] vb, input logic vc);
        @(negedge clk);
        if (pendValid) checkOutput(pendTag, {s, cout, overflow}, pendExpected);
        a            = va;
        b            = vb;
        cin          = vc;
        pendExpected = refModel(va, vb, vc);
        pendTag      = tag;
        pendValid    = 1'b1;
    endtask

    // Check the last outstanding vector without driving a new one.
    task automatic flushStream();
        @(negedge clk);
        if (pendValid) checkOutput(pendTag, {s, cout, overflow}, pendExpected);
        pendValid = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        pendValid   = 1'b0;
        pendTag     = "";
        pendExpected = '0;
        rst_n = 1'b0;
        a     = 8'h5A;
        b     = 8'hA5;
        cin   = 1'b0;

        #12;
        checkOutput("reset_init", {s, cout, overflow}, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner vectors streamed back to back.
        applyStimulus("add_01_01", 8'h01, 8'h01, 1'b0);
        applyStimulus("add_02_fe", 8'h02, 8'hFE, 1'b0);
        applyStimulus("add_ff_ff", 8'hFF, 8'hFF, 1'b0);
        applyStimulus("sub_19_b1", 8'h19, 8'hB1, 1'b1);
        applyStimulus("sub_3d_35", 8'h3D, 8'h35, 1'b1);
        applyStimulus("sub_87_07", 8'h87, 8'h07, 1'b1);
        applyStimulus("ovf_81_81", 8'h81, 8'h81, 1'b0);
        applyStimulus("ovf_80_80", 8'h80, 8'h80, 1'b0);
        applyStimulus("ovf_7f_1f", 8'h7F, 8'h1F, 1'b0);
        flushStream();

        // Spot checks of literal values from the reference table.
        checkOutput("lit_7f_1f_S", {s, 2'b00}, {8'h9E, 2'b00});

        // Asynchronous reset asserted between edges while outputs are nonzero.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", {s, cout, overflow}, 10'd0);
        a   = 8'h11;
        b   = 8'h22;
        cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hold", {s, cout, overflow}, 10'd0);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("reset_release", {s, cout, overflow}, 10'd0);
        @(posedge clk);
        #1;
        checkOutput("reset_resume", {s, cout, overflow}, refModel(8'h11, 8'h22, 1'b0));

        // Random back-to-back stream.
        for (int i = 0; i < 1000; i++) begin
            applyStimulus("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
        end
        flushStream();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_csa
